// File: rtl/cla_adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead adder among
// NUM_REQ valid/ready requesters; operands are registered before the adder.
module cla_adder_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    input  logic [NUM_REQ-1:0]    req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [31:0]     op_a_q, op_a_d;
    logic [31:0]     op_b_q, op_b_d;
    logic            op_cin_q, op_cin_d;
    logic [ID_W-1:0] op_id_q, op_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;
    logic [31:0]     rsp_sum_q, rsp_sum_d;
    logic            rsp_cout_q, rsp_cout_d;
    logic            rsp_ovf_q, rsp_ovf_d;

    logic            win_found;
    logic [ID_W-1:0] win_id;
    logic [ID_W:0]   idx;
    logic            accept_en;
    logic            accept;
    logic [31:0]     add_sum;
    logic            add_cout;
    logic            add_ovf;

    carry_look_ahead_adder u_adder (
        .a    (op_a_q),
        .b    (op_b_q),
        .cin  (op_cin_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign add_ovf = (op_a_q[31] == op_b_q[31]) && (add_sum[31] != op_a_q[31]);

    // Cyclic search starting one past the last winner.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
            if (idx >= (ID_W+1)'(NUM_REQ)) begin
                idx = idx - (ID_W+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[ID_W-1:0];
            end
        end
    end

    always_comb begin
        accept_en = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
        accept    = accept_en && win_found && !rst;
        req_ready = '0;
        if (accept) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        op_id_d     = op_id_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_cout_d  = rsp_cout_q;
        rsp_ovf_d   = rsp_ovf_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = op_id_q;
                rsp_sum_d   = add_sum;
                rsp_cout_d  = add_cout;
                rsp_ovf_d   = add_ovf;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = accept ? EXEC : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (accept) begin
            op_a_d   = req_a[32*win_id +: 32];
            op_b_d   = req_b[32*win_id +: 32];
            op_cin_d = req_cin[win_id];
            op_id_d  = win_id;
            rr_ptr_d = win_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= ID_W'(NUM_REQ - 1);
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            op_id_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            op_id_q     <= op_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_cout_q  <= rsp_cout_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// 32-bit adder: 4-bit lookahead groups, group carries chained.
module carry_look_ahead_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            c[4*k+1] = g[4*k]
                     | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
        sum  = p ^ c[31:0];
        cout = c[32];
    end

endmodule

// File: tb/tb_cla_adder_arbiter.sv
// Scoreboard bench for cla_adder_arbiter: expected results queued on
// accept, compared when the response handshake completes.
module tb_cla_adder_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [31:0]    rsp_sum;
    logic           rsp_cout;
    logic           rsp_ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [35:0] exp_q[$];
    int          gnt_id_q[$];
    int          gnt_cyc_q[$];
    logic [35:0] e;

    cla_adder_arbiter #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {id, cout, ovf, sum}
    function automatic logic [35:0] model(input int id, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
        logic [32:0] s;
        logic        v;
        s = {1'b0, a} + {1'b0, b} + {32'd0, c};
        v = (a[31] == b[31]) && (s[31] != a[31]);
        return {id[1:0], s[32], v, s[31:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot", 64'($countones(req_ready) <= 1), 64'd1);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back(model(i, req_a[32*i +: 32],
                                          req_b[32*i +: 32], req_cin[i]));
                    gnt_id_q.push_back(i);
                    gnt_cyc_q.push_back(cyc);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp", {28'd0, rsp_id, rsp_cout, rsp_ovf, rsp_sum},
                        {28'd0, e});
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic c);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_cin[i]        = c;
        req_valid[i]      = 1'b1;
    endtask

    task automatic wait_accept(input int i);
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin
                @(posedge clk);
                #1;
                req_valid[i] = 1'b0;
                return;
            end
        end
        chk($sformatf("accept_timeout_%0d", i), 64'd0, 64'd1);
        req_valid[i] = 1'b0;
    endtask

    task automatic send(input int i, input logic [31:0] a,
                        input logic [31:0] b, input logic c);
        set_req(i, a, b, c);
        wait_accept(i);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("drain_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        gnt_id_q.delete();
        gnt_cyc_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;

        // reset state with all requesters asking
        @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp", {28'd0, rsp_id, rsp_cout, rsp_ovf, rsp_sum}, 64'd0);
        @(posedge clk);
        #1;
        req_valid = '0;
        rst       = 1'b0;

        // latency of a lone request
        set_req(0, 32'd10, 32'd20, 1'b0);
        @(negedge clk);
        chk("lat_ready", 64'(req_ready), 64'b0001);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("lat_exec_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("lat_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("lat_rsp_sum", 64'(rsp_sum), 64'd30);
        drain();

        // directed arithmetic cases
        send(2, 32'd9, 32'd11, 1'b1);
        drain();
        send(1, 32'h0FFF_FFFF, 32'd1, 1'b0);
        drain();
        send(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drain();
        send(0, 32'h7FFF_FFFF, 32'd1, 1'b0);
        drain();
        send(1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        drain();

        // round robin with everyone contending
        do_reset();
        for (int i = 0; i < N; i++) begin
            fork
                automatic int r = i;
                begin
                    for (int k = 0; k < 3; k++) begin
                        send(r, 32'(100 * r + k), 32'(k * 7), r[0]);
                    end
                end
            join_none
        end
        wait fork;
        drain();
        chk("rr_count", 64'(gnt_id_q.size()), 64'd12);
        for (int k = 0; k < 6 && k < gnt_id_q.size(); k++) begin
            chk($sformatf("rr_order_%0d", k), 64'(gnt_id_q[k]), 64'(k % N));
            if (k > 0) begin
                chk($sformatf("rr_gap_%0d", k),
                    64'(gnt_cyc_q[k] - gnt_cyc_q[k-1]), 64'd2);
            end
        end

        // backpressure holds the response and closes the accept window
        rsp_ready = 1'b0;
        send(0, 32'h1234_0000, 32'h0000_5678, 1'b1);
        set_req(1, 32'd5, 32'd6, 1'b0);
        @(posedge clk);
        #1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp", {28'd0, rsp_id, rsp_cout, rsp_ovf, rsp_sum},
                {28'd0, model(0, 32'h1234_0000, 32'h0000_5678, 1'b1)});
            chk("bp_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept", 64'(req_ready), 64'b0010);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        drain();

        // reset during EXEC drops the op and restores the pointer
        send(2, 32'd77, 32'd88, 1'b0);
        rst = 1'b1;
        set_req(1, 32'd1000, 32'd2000, 1'b0);
        set_req(3, 32'd3000, 32'd4000, 1'b1);
        @(negedge clk);
        chk("rstx_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        chk("rstx_valid", 64'(rsp_valid), 64'd0);
        chk("rstx_ready2", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rstx_first", 64'(req_ready), 64'b0010);
        wait_accept(1);
        wait_accept(3);
        drain();

        // random traffic
        for (int n = 0; n < 12; n++) begin
            send($urandom_range(0, N - 1), $urandom, $urandom,
                 1'($urandom_range(0, 1)));
        end
        drain();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cla_adder_arbiter.md
Name: cla_adder_arbiter

Overview:
Shares one 32-bit carry_look_ahead_adder instance among NUM_REQ requesters using round-robin arbitration. Each requester has a valid/ready operand channel. One response channel returns sum, carry, signed overflow and the requester ID. The block sits between the requester clients and the shared adder, which it instantiates internally; operands to the adder are registered.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, $clog2(NUM_REQ), width of the requester ID (derived; do not override)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept strobe; at most one bit high (one-hot or zero)
req_a  input  NUM_REQ*32  operand A; requester i uses bits [32*i+31:32*i]
req_b  input  NUM_REQ*32  operand B, same packing as req_a
req_cin  input  NUM_REQ  carry-in per requester
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  index of the requester that owns the response
rsp_sum  output  32  a+b+cin, low 32 bits
rsp_cout  output  1  carry out of bit 31
rsp_ovf  output  1  signed overflow: (a[31]==b[31]) && (sum[31]!=a[31])

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, rsp_id=0.
  - req_ready forced to 0 while rst=1.
  - Reset mid-operation discards the captured operands and any pending response without emitting it.
- Arbitration:
  - Winner is the first requester with req_valid=1, searching cyclically from rr_ptr+1.
  - req_ready[winner] is combinational from req_valid and state, and is asserted only in an accept window.
  - On accept: capture a, b, cin and ID into operand registers; set rr_ptr=winner.
  - rr_ptr changes only on accept.
- Handshake rules:
  - A transfer occurs when req_valid[i] && req_ready[i].
  - Requesters hold operands stable while valid and not yet accepted.
  - Deasserting valid before acceptance is legal and is simply not granted.
- States:
  - IDLE: accept window open. If any valid: accept, go to EXEC. Otherwise stay.
  - EXEC: the adder evaluates the registered operands. At the clock edge, register sum, cout, ovf and id into the rsp_* registers, set rsp_valid=1, go to RESP. No accept in EXEC.
  - RESP: rsp_valid=1; rsp_* outputs held stable.
    - If rsp_ready=0: stay, with no accept window.
    - If rsp_ready=1 and any req_valid: accept the new winner in the same cycle, rsp_valid drops at the edge, go to EXEC.
    - If rsp_ready=1 and no req_valid: rsp_valid drops at the edge, go to IDLE.
- Latency and throughput:
  - An accept at edge T gives rsp_valid=1 from edge T+1 (after EXEC).
  - Accept-to-response is 2 cycles.
  - Peak throughput is one operation per 2 cycles.
- Arithmetic:
  - Full 33-bit result of a+b+cin: rsp_cout is bit 32.
  - Wrap-around is modulo 2^32 in rsp_sum.
  - ovf is computed from the registered operands, independent of cout.
- Boundary conditions:
  - All requesters idle: no state change.
  - Requester valid continuously: it is granted at most once per NUM_REQ grants while others are contending.
  - The rsp_* outputs are unchanged during backpressure.
  - rsp_ready=1 while rsp_valid=0 has no effect.

Test Plan:
- Req0 a=10, b=20, cin=0 alone -> req_ready[0] in the accept cycle; 2 cycles later rsp_valid=1, rsp_sum=30, rsp_cout=0, rsp_ovf=0, rsp_id=0.
- Req2 a=9, b=11, cin=1 -> rsp_sum=21, rsp_id=2. Req1 a=32'h0FFFFFFF, b=1 -> rsp_sum=32'h10000000, rsp_cout=0.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF, cin=1 -> rsp_sum=32'hFFFFFFFF, rsp_cout=1, rsp_ovf=0. a=32'h7FFFFFFF, b=1 -> rsp_sum=32'h80000000, rsp_ovf=1, rsp_cout=0.
- All 4 req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0,1; a new grant every 2 cycles; req_ready always one-hot or zero.
- rsp_ready=0 for 5 cycles with req_valid pending -> rsp_* outputs stable and req_ready=0 throughout. Raising rsp_ready gives a new accept in that same cycle.
- rst=1 during EXEC -> next cycle rsp_valid=0, state IDLE. After release with req1 and req3 valid, req1 is granted first (pointer reset).
